// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - opcodes, FSM encoding and defaults for the shift sequencer
//
// Purpose : shared definitions for the issue-side client of the two-edge
//           synchronous shifter in the execute stage.
// Contents: SHIFT_* 2-bit opcode constants, sequencer state encoding,
//           default tag width, opcode helper functions.
package shift_sequencer_pkg;

   localparam int TAG_WIDTH_DEFAULT = 4;

   localparam logic [1:0] SHIFT_SLL     = 2'b00;
   localparam logic [1:0] SHIFT_SRL     = 2'b01;
   localparam logic [1:0] SHIFT_SRA     = 2'b10;
   localparam logic [1:0] SHIFT_ILLEGAL = 2'b11;

   // IDLE  : waiting for a request
   // EDGE1 : operands on the shifter, next edge is its intermediate capture
   // EDGE2 : shifter result valid, capture into the response slot if free
   // STALL : result ready but response slot occupied; operands held
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EDGE1 = 2'b01,
      ST_EDGE2 = 2'b10,
      ST_STALL = 2'b11
   } seq_state_t;

   function automatic logic is_illegal(input logic [1:0] op);
      return (op == SHIFT_ILLEGAL);
   endfunction

   // The shifter has no defined behaviour for 11, so an illegal request
   // runs through it as a harmless SLL whose result is then discarded.
   function automatic logic [1:0] shifter_op(input logic [1:0] op);
      return is_illegal(op) ? SHIFT_SLL : op;
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response handshake bundle of the shift sequencer
//
// Purpose : groups the CPU-side request channel and response channel.
// Signals : reqValid/reqReady/reqOperation/reqLeft/reqAmount/reqTag  request channel
//           respValid/respReady/respResult/respError/respTag          response channel
// Modports: master - CPU pipeline side (issues requests, consumes responses)
//           slave  - sequencer side
interface shift_sequencer_if
   import shift_sequencer_pkg::*;
#(
   parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT
);

   logic                 reqValid;
   logic                 reqReady;
   logic [1:0]           reqOperation;
   logic [31:0]          reqLeft;
   logic [4:0]           reqAmount;
   logic [TAG_WIDTH-1:0] reqTag;

   logic                 respValid;
   logic                 respReady;
   logic [31:0]          respResult;
   logic                 respError;
   logic [TAG_WIDTH-1:0] respTag;

   modport master (
      output reqValid, reqOperation, reqLeft, reqAmount, reqTag, respReady,
      input  reqReady, respValid, respResult, respError, respTag
   );

   modport slave (
      input  reqValid, reqOperation, reqLeft, reqAmount, reqTag, respReady,
      output reqReady, respValid, respResult, respError, respTag
   );

endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - holds shift requests across the shifter's two edges and returns results
//
// Purpose : accepts shift requests, keeps operation/operands stable on the
//           shifter inputs for both required edges, samples the shifter
//           result at the second edge into a one-entry response slot.
// Ports   : clock           system clock, rising edge
//           resetN          asynchronous active-low reset
//           bus             shift_sequencer_if.slave request/response channels
//           shOperation     to shifter operation (00 for illegal requests)
//           shLeftOperand   to shifter left operand
//           shRightOperand  to shifter shift amount
//           shResult        from shifter, valid in the cycle after its first edge
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT
)
(
   input  logic                    clock,
   input  logic                    resetN,
   shift_sequencer_if.slave        bus,
   output logic [1:0]              shOperation,
   output logic [31:0]             shLeftOperand,
   output logic [4:0]              shRightOperand,
   input  logic [31:0]             shResult
);

   seq_state_t           state;
   seq_state_t           state_next;

   // Low while in reset and until the first edge after release, so reqReady
   // stays deasserted throughout reset.
   logic                 alive;

   logic                 hold_illegal;
   logic [TAG_WIDTH-1:0] hold_tag;

   logic                 slot_free;
   logic                 capture;
   logic                 accept;
   logic                 consume;

   // The slot counts as free when it is empty or being drained this edge,
   // which lets capture and consume coincide without a bubble.
   assign slot_free = !bus.respValid || bus.respReady;
   assign consume   = bus.respValid && bus.respReady;
   assign accept    = bus.reqValid && bus.reqReady;

   always_comb begin
      state_next   = state;
      bus.reqReady = 1'b0;
      capture      = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.reqReady = alive;
            if (bus.reqValid && alive) begin
               state_next = ST_EDGE1;
            end
         end
         ST_EDGE1: begin
            state_next = ST_EDGE2;
         end
         ST_EDGE2: begin
            if (slot_free) begin
               capture      = 1'b1;
               bus.reqReady = 1'b1;
               state_next   = bus.reqValid ? ST_EDGE1 : ST_IDLE;
            end else begin
               state_next = ST_STALL;
            end
         end
         ST_STALL: begin
            // Operands are still held, so the shifter keeps re-producing the
            // same result and it can be captured whenever the slot frees.
            if (slot_free) begin
               capture    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state          <= ST_IDLE;
         alive          <= 1'b0;
         shOperation    <= SHIFT_SLL;
         shLeftOperand  <= '0;
         shRightOperand <= '0;
         hold_illegal   <= 1'b0;
         hold_tag       <= '0;
         bus.respValid  <= 1'b0;
         bus.respResult <= '0;
         bus.respError  <= 1'b0;
         bus.respTag    <= '0;
      end else begin
         state <= state_next;
         alive <= 1'b1;

         // Shifter inputs move only on an accept; at every other edge the
         // previous operands stay put.
         if (accept) begin
            shOperation    <= shifter_op(bus.reqOperation);
            shLeftOperand  <= bus.reqLeft;
            shRightOperand <= bus.reqAmount;
            hold_illegal   <= is_illegal(bus.reqOperation);
            hold_tag       <= bus.reqTag;
         end

         // Response fields change only on capture, keeping them stable while
         // a response waits for respReady.
         if (capture) begin
            bus.respValid  <= 1'b1;
            bus.respResult <= hold_illegal ? 32'd0 : shResult;
            bus.respError  <= hold_illegal;
            bus.respTag    <= hold_tag;
         end else if (consume) begin
            bus.respValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized self-checking bench for shift_sequencer
module tb_shift_sequencer;
   import shift_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic [1:0]  shOperation;
   logic [31:0] shLeftOperand;
   logic [4:0]  shRightOperand;
   logic [31:0] shResult = 32'd0;

   int total = 0;
   int bad   = 0;

   shift_sequencer_if #(.TAG_WIDTH(4)) bus ();

   shift_sequencer #(.TAG_WIDTH(4)) dut (
      .clock          (clock),
      .resetN         (resetN),
      .bus            (bus),
      .shOperation    (shOperation),
      .shLeftOperand  (shLeftOperand),
      .shRightOperand (shRightOperand),
      .shResult       (shResult)
   );

   always #5 clock = ~clock;

   // Execute-stage shifter stand-in: result registered one edge after the
   // operands are seen.
   always @(posedge clock) begin
      case (shOperation)
         2'b00:   shResult <= shLeftOperand << shRightOperand;
         2'b01:   shResult <= shLeftOperand >> shRightOperand;
         2'b10:   shResult <= $unsigned($signed(shLeftOperand) >>> shRightOperand);
         default: shResult <= 32'd0;
      endcase
   end

   // Expected response {error, result} from plain arithmetic on the request.
   function automatic logic [32:0] ref_resp(input logic [1:0] op, input logic [31:0] left,
                                            input logic [4:0] amt);
      logic [63:0] p;
      logic [63:0] w;
      p = 64'd1;
      for (int k = 0; k < 32; k++) if (k < int'(amt)) p = p * 64'd2;
      case (op)
         2'b00: begin w = {32'd0, left} * p; return {1'b0, w[31:0]}; end
         2'b01: begin w = {32'd0, left} / p; return {1'b0, w[31:0]}; end
         2'b10: begin
            if (left[31]) begin
               w = {32'd0, ~left} / p;
               return {1'b0, ~w[31:0]};
            end
            w = {32'd0, left} / p;
            return {1'b0, w[31:0]};
         end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   // Presents one request and returns right after the edge that accepted it.
   task automatic offer(input logic [1:0] op, input logic [31:0] left, input logic [4:0] amt,
                        input logic [3:0] tag);
      int guard;
      @(negedge clock);
      bus.reqValid     = 1'b1;
      bus.reqOperation = op;
      bus.reqLeft      = left;
      bus.reqAmount    = amt;
      bus.reqTag       = tag;
      guard = 0;
      while (!bus.reqReady && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 20) begin
         total++; bad++;
         $display("FAIL offer_timeout: reqReady=%0b required 1 within 20 cycles", bus.reqReady);
      end
      @(posedge clock);
      #1;
      bus.reqValid = 1'b0;
   endtask

   task automatic do_single(input logic [1:0] op, input logic [31:0] left, input logic [4:0] amt,
                            input logic [3:0] tag, output logic [31:0] res, output logic err,
                            output logic [3:0] rtag, output int lat);
      bus.respReady = 1'b0;
      offer(op, left, amt, tag);
      lat = 0;
      while (!bus.respValid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      res  = bus.respResult;
      err  = bus.respError;
      rtag = bus.respTag;
      @(negedge clock);
      bus.respReady = 1'b1;
      @(posedge clock);
      #1;
      bus.respReady = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      total++;
      if ({bus.reqReady, bus.respValid, bus.respError} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: ready/valid/err=%b required 000",
                  {bus.reqReady, bus.respValid, bus.respError});
      end
      total++;
      if ({bus.respResult, bus.respTag, shOperation, shLeftOperand, shRightOperand} !== 75'd0) begin
         bad++;
         $display("FAIL reset_data: result=%h tag=%h op=%b left=%h amt=%0d required all zero",
                  bus.respResult, bus.respTag, shOperation, shLeftOperand, shRightOperand);
      end
      resetN = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (bus.reqReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready_after: reqReady=%b required 1", bus.reqReady);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops  [4] = '{2'b00, 2'b10, 2'b01, 2'b01};
      logic [31:0] lefts[4] = '{32'h00000001, 32'h80000000, 32'hF0000000, 32'h12345678};
      logic [4:0]  amts [4] = '{5'd31, 5'd20, 5'd4, 5'd0};
      logic [31:0] wants[4] = '{32'h80000000, 32'hFFFFF800, 32'h0F000000, 32'h12345678};
      logic [31:0] res;
      logic        err;
      logic [3:0]  rtag;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         do_single(ops[i], lefts[i], amts[i], 4'(i + 3), res, err, rtag, lat);
         total++;
         if ({err, res} !== {1'b0, wants[i]}) begin
            bad++;
            $display("FAIL directed_%0d: err=%b result=%h required err=0 result=%h",
                     i, err, res, wants[i]);
         end
         total++;
         if (rtag !== 4'(i + 3) || lat != 2) begin
            bad++;
            $display("FAIL directed_tag_lat_%0d: tag=%0d lat=%0d required tag=%0d lat=2",
                     i, rtag, lat, i + 3);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] res;
      logic        err;
      logic [3:0]  rtag;
      int          lat;
      logic [1:0]  op;
      logic [31:0] left;
      logic [4:0]  amt;
      logic [3:0]  tag;
      logic [32:0] exp;
      for (int i = 0; i < 24; i++) begin
         op   = 2'($urandom_range(0, 3));
         left = $urandom;
         case ($urandom_range(0, 3))
            0:       amt = 5'd0;
            1:       amt = 5'd16;
            default: amt = 5'($urandom_range(0, 31));
         endcase
         tag = 4'($urandom);
         exp = ref_resp(op, left, amt);
         do_single(op, left, amt, tag, res, err, rtag, lat);
         total++;
         if ({err, res, rtag} !== {exp, tag} || lat != 2) begin
            bad++;
            $display("FAIL random_%0d: op=%b left=%h amt=%0d got err=%b res=%h tag=%h lat=%0d required err=%b res=%h tag=%h lat=2",
                     i, op, left, amt, err, res, rtag, lat, exp[32], exp[31:0], tag);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ops  [4];
      logic [31:0] lefts[4];
      logic [4:0]  amts [4];
      logic [32:0] exp_q[$];
      logic [3:0]  tag_q[$];
      int          acc_cyc[$];
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      logic        acc;
      for (int i = 0; i < 4; i++) begin
         ops[i]   = 2'($urandom_range(0, 2));
         lefts[i] = $urandom;
         amts[i]  = 5'($urandom_range(0, 31));
      end
      @(negedge clock);
      bus.respReady    = 1'b1;
      bus.reqValid     = 1'b1;
      bus.reqOperation = ops[0];
      bus.reqLeft      = lefts[0];
      bus.reqAmount    = amts[0];
      bus.reqTag       = 4'd0;
      while (got < 4 && cyc < 60) begin
         if (bus.respValid && bus.respReady) begin
            total++;
            if ({bus.respError, bus.respResult, bus.respTag} !== {exp_q[0], tag_q[0]}) begin
               bad++;
               $display("FAIL b2b_resp_%0d: err=%b res=%h tag=%0d required err=%b res=%h tag=%0d",
                        got, bus.respError, bus.respResult, bus.respTag,
                        exp_q[0][32], exp_q[0][31:0], tag_q[0]);
            end
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            got++;
         end
         acc = bus.reqValid && bus.reqReady;
         if (acc) begin
            exp_q.push_back(ref_resp(bus.reqOperation, bus.reqLeft, bus.reqAmount));
            tag_q.push_back(bus.reqTag);
            acc_cyc.push_back(cyc);
            sent++;
         end
         @(posedge clock);
         #1;
         if (acc) begin
            if (sent < 4) begin
               bus.reqOperation = ops[sent];
               bus.reqLeft      = lefts[sent];
               bus.reqAmount    = amts[sent];
               bus.reqTag       = 4'(sent);
            end else begin
               bus.reqValid = 1'b0;
            end
         end
         @(negedge clock);
         cyc++;
      end
      bus.respReady = 1'b0;
      total++;
      if (got != 4 || sent != 4) begin
         bad++;
         $display("FAIL b2b_count: accepted=%0d answered=%0d required 4 and 4", sent, got);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         total++;
         if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
            bad++;
            $display("FAIL b2b_spacing_%0d: gap=%0d cycles required 2", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] exp_a, exp_b;
      exp_a = ref_resp(2'b01, 32'hA5A5_0000, 5'd8);
      exp_b = ref_resp(2'b10, 32'h8123_4567, 5'd12);
      bus.respReady = 1'b0;
      offer(2'b01, 32'hA5A5_0000, 5'd8, 4'd5);
      offer(2'b10, 32'h8123_4567, 5'd12, 4'd6);
      repeat (2) @(posedge clock);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         total++;
         if (dut.state !== ST_STALL || bus.reqReady !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall_%0d: state=%0d reqReady=%b required STALL and 0",
                     c, dut.state, bus.reqReady);
         end
         total++;
         if ({shOperation, shLeftOperand, shRightOperand} !== {2'b10, 32'h8123_4567, 5'd12}) begin
            bad++;
            $display("FAIL bp_hold_%0d: op=%b left=%h amt=%0d required 10 81234567 12",
                     c, shOperation, shLeftOperand, shRightOperand);
         end
         total++;
         if ({bus.respValid, bus.respError, bus.respResult, bus.respTag} !== {1'b1, exp_a, 4'd5}) begin
            bad++;
            $display("FAIL bp_first_stable_%0d: valid=%b err=%b res=%h tag=%0d required 1 %b %h 5",
                     c, bus.respValid, bus.respError, bus.respResult, bus.respTag, exp_a[32], exp_a[31:0]);
         end
      end
      bus.respReady = 1'b1;
      @(negedge clock);
      total++;
      if ({bus.respValid, bus.respError, bus.respResult, bus.respTag} !== {1'b1, exp_b, 4'd6}) begin
         bad++;
         $display("FAIL bp_second: valid=%b err=%b res=%h tag=%0d required 1 %b %h 6",
                  bus.respValid, bus.respError, bus.respResult, bus.respTag, exp_b[32], exp_b[31:0]);
      end
      @(negedge clock);
      bus.respReady = 1'b0;
      total++;
      if (bus.respValid !== 1'b0 || dut.state !== ST_IDLE) begin
         bad++;
         $display("FAIL bp_drain: respValid=%b state=%0d required 0 and IDLE", bus.respValid, dut.state);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] res;
      logic        err;
      logic [3:0]  rtag;
      int          lat;
      do_single(2'b11, 32'hDEADBEEF, 5'd7, 4'd9, res, err, rtag, lat);
      total++;
      if ({err, res, rtag} !== {1'b1, 32'd0, 4'd9} || lat != 2) begin
         bad++;
         $display("FAIL illegal_resp: err=%b res=%h tag=%0d lat=%0d required err=1 res=0 tag=9 lat=2",
                  err, res, rtag, lat);
      end
      total++;
      if ({shOperation, shLeftOperand} !== {2'b00, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL illegal_shop: op=%b left=%h required 00 deadbeef", shOperation, shLeftOperand);
      end
      do_single(2'b01, 32'hDEADBEEF, 5'd7, 4'd10, res, err, rtag, lat);
      total++;
      if ({err, res, rtag} !== {1'b0, 32'h01BD5B7D, 4'd10} || lat != 2) begin
         bad++;
         $display("FAIL illegal_next: err=%b res=%h tag=%0d lat=%0d required err=0 res=01bd5b7d tag=10 lat=2",
                  err, res, rtag, lat);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      logic        err;
      logic [3:0]  rtag;
      int          lat;
      int          guard;
      for (int pass = 0; pass < 2; pass++) begin
         bus.respReady = 1'b0;
         offer(2'b00, 32'h0000_00FF, 5'd4, 4'd1);
         if (pass == 1) begin
            offer(2'b01, 32'hFFFF_0000, 5'd16, 4'd2);
            guard = 0;
            while (dut.state !== ST_STALL && guard < 10) begin
               @(posedge clock);
               #1;
               guard++;
            end
         end
         @(negedge clock);
         total++;
         if (dut.state !== (pass == 0 ? ST_EDGE1 : ST_STALL)) begin
            bad++;
            $display("FAIL midop_state_%0d: state=%0d required %0d",
                     pass, dut.state, pass == 0 ? ST_EDGE1 : ST_STALL);
         end
         resetN = 1'b0;
         #1;
         total++;
         if ({bus.reqReady, bus.respValid, bus.respError, bus.respResult, bus.respTag,
              shOperation, shLeftOperand, shRightOperand} !== 78'd0) begin
            bad++;
            $display("FAIL midop_reset_%0d: ready=%b valid=%b err=%b res=%h tag=%h op=%b left=%h amt=%0d required all zero",
                     pass, bus.reqReady, bus.respValid, bus.respError, bus.respResult, bus.respTag,
                     shOperation, shLeftOperand, shRightOperand);
         end
         @(negedge clock);
         resetN = 1'b1;
         do_single(2'b00, 32'h0000_0003, 5'd16, 4'd7, res, err, rtag, lat);
         total++;
         if ({err, res, rtag} !== {1'b0, 32'h0003_0000, 4'd7} || lat != 2) begin
            bad++;
            $display("FAIL midop_fresh_%0d: err=%b res=%h tag=%0d lat=%0d required err=0 res=00030000 tag=7 lat=2",
                     pass, err, res, rtag, lat);
         end
      end
   endtask

   initial begin
      bus.reqValid     = 1'b0;
      bus.reqOperation = 2'b00;
      bus.reqLeft      = 32'd0;
      bus.reqAmount    = 5'd0;
      bus.reqTag       = 4'd0;
      bus.respReady    = 1'b0;
      repeat (2) @(posedge clock);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
